// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
//   Shared widths and constants for the hazard/flush controller and its
//   scoreboard. These values are the defaults of the module parameters.
//   Ports: none (package).
package pipeline_ctrl_pkg;

    localparam int              REG_ADDR_SIZE = 5;              // register address width
    localparam int              PC_SIZE       = 32;             // fetch address width
    localparam logic [31:0]     TRAP_VECTOR   = 32'h0000_0100;  // exception redirect target
    localparam int              BUSY_W        = 32;             // one busy bit per architectural register

endpackage

// File: rtl/pipeline_ctrl_pipe_scoreboard.sv
// pipe_scoreboard
//   Tracks the destination register of the instructions sitting in EX, MEM
//   and WB, and reports which registers still have a write pending.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   advance      1 = pipe moves this edge (memory stage not stalling)
//   squash       1 = the instruction currently in EX is discarded this edge
//   issue_wr     1 = a register-writing instruction enters EX this edge
//   issue_rd     destination register of the entering instruction
//   busy_vec     bit r = register r is written by an in-flight instruction
module pipe_scoreboard
    import pipeline_ctrl_pkg::*;
#(
    parameter int RA_W = REG_ADDR_SIZE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    input  logic              squash,
    input  logic              issue_wr,
    input  logic [RA_W-1:0]   issue_rd,
    output logic [BUSY_W-1:0] busy_vec
);

    logic            ex_v, mem_v, wb_v;
    logic [RA_W-1:0] ex_rd, mem_rd, wb_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_v   <= 1'b0;
            mem_v  <= 1'b0;
            wb_v   <= 1'b0;
            ex_rd  <= '0;
            mem_rd <= '0;
            wb_rd  <= '0;
        end else if (advance) begin
            wb_v   <= mem_v;
            wb_rd  <= mem_rd;
            // A squashed EX instruction never reaches MEM; older MEM/WB
            // producers are untouched and keep their busy bits.
            mem_v  <= ex_v && !squash;
            mem_rd <= ex_rd;
            ex_v   <= issue_wr;
            ex_rd  <= issue_rd;
        end else if (squash) begin
            // Pipe is held but the flush is single-cycle, so drop EX now.
            ex_v   <= 1'b0;
        end
    end

    // Writes to r0 are filtered at issue, but mask bit 0 anyway so r0 can
    // never cause a stall.
    always_comb begin
        busy_vec = '0;
        if (ex_v)  busy_vec[ex_rd]  = 1'b1;
        if (mem_v) busy_vec[mem_rd] = 1'b1;
        if (wb_v)  busy_vec[wb_rd]  = 1'b1;
        busy_vec[0] = 1'b0;
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Hazard and flush controller for the 5-stage core (no forwarding).
//   Stalls decode on read-after-write hazards against EX/MEM/WB, and turns
//   EX redirect requests / exceptions into a registered one-cycle flush
//   plus a fetch redirect.
// Handshake: decode presents dec_valid; the instruction is accepted into EX
//   on any edge where dec_valid=1 and stall_decode=0 and flush_out=0 and
//   mem_stall=0. Decode must hold its instruction stable while stalled.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   dec_valid                    decode holds a valid instruction
//   dec_rs1/rs2_addr, _used      source registers and whether they are read
//   dec_rd_addr, dec_rd_wen      destination register and write enable
//   ex_redirect_req/_addr        taken branch/jump in EX and its target
//   ex_exception                 EX instruction raised an exception
//   mem_stall                    memory stage busy; whole pipe holds
//   stall_fetch/decode/execute   hold signals for the front stages
//   flush_out                    one-cycle flush of fetch/decode/execute
//   redirect_valid/_addr         load redirect_addr into the PC
//   busy_vec                     registers with a pending write
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int              RA_W     = REG_ADDR_SIZE,
    parameter int              PC_W     = PC_SIZE,
    parameter logic [PC_W-1:0] TRAP_VEC = PC_W'(TRAP_VECTOR)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_valid,
    input  logic [RA_W-1:0]   dec_rs1_addr,
    input  logic [RA_W-1:0]   dec_rs2_addr,
    input  logic              dec_rs1_used,
    input  logic              dec_rs2_used,
    input  logic [RA_W-1:0]   dec_rd_addr,
    input  logic              dec_rd_wen,
    input  logic              ex_redirect_req,
    input  logic [PC_W-1:0]   ex_redirect_addr,
    input  logic              ex_exception,
    input  logic              mem_stall,
    output logic              stall_fetch,
    output logic              stall_decode,
    output logic              stall_execute,
    output logic              flush_out,
    output logic              redirect_valid,
    output logic [PC_W-1:0]   redirect_addr,
    output logic [BUSY_W-1:0] busy_vec
);

    logic            flush_q, redir_q;
    logic [PC_W-1:0] addr_q;
    logic            hazard, issue, issue_wr, flush_req;

    assign hazard = dec_valid &&
                    ((dec_rs1_used && busy_vec[dec_rs1_addr]) ||
                     (dec_rs2_used && busy_vec[dec_rs2_addr]));

    assign issue    = dec_valid && !hazard && !mem_stall && !flush_q;
    assign issue_wr = issue && dec_rd_wen && (dec_rd_addr != '0);

    // While stalled the requester stays in EX and asks again later; while
    // flushing, the requester has already moved on so the request is stale.
    assign flush_req = (ex_exception || ex_redirect_req) && !mem_stall && !flush_q;

    pipe_scoreboard #(.RA_W(RA_W)) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .advance  (!mem_stall),
        .squash   (flush_q),
        .issue_wr (issue_wr),
        .issue_rd (dec_rd_addr),
        .busy_vec (busy_vec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            flush_q <= 1'b0;
            redir_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            flush_q <= flush_req;
            redir_q <= flush_req;
            if (flush_req) begin
                addr_q <= ex_exception ? TRAP_VEC : ex_redirect_addr;
            end
        end
    end

    assign flush_out      = flush_q;
    assign redirect_valid = redir_q;
    assign redirect_addr  = addr_q;

    // Hazard stall leaves execute running so a bubble flows into EX;
    // a flush cycle releases every stall.
    assign stall_execute = mem_stall && !flush_q;
    assign stall_decode  = (mem_stall || hazard) && !flush_q;
    assign stall_fetch   = stall_decode;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        dec_valid;
    logic [4:0]  dec_rs1_addr, dec_rs2_addr, dec_rd_addr;
    logic        dec_rs1_used, dec_rs2_used, dec_rd_wen;
    logic        ex_redirect_req;
    logic [31:0] ex_redirect_addr;
    logic        ex_exception;
    logic        mem_stall;
    logic        stall_fetch, stall_decode, stall_execute;
    logic        flush_out, redirect_valid;
    logic [31:0] redirect_addr;
    logic [31:0] busy_vec;

    int checks = 0;
    int errors = 0;

    pipeline_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .dec_valid        (dec_valid),
        .dec_rs1_addr     (dec_rs1_addr),
        .dec_rs2_addr     (dec_rs2_addr),
        .dec_rs1_used     (dec_rs1_used),
        .dec_rs2_used     (dec_rs2_used),
        .dec_rd_addr      (dec_rd_addr),
        .dec_rd_wen       (dec_rd_wen),
        .ex_redirect_req  (ex_redirect_req),
        .ex_redirect_addr (ex_redirect_addr),
        .ex_exception     (ex_exception),
        .mem_stall        (mem_stall),
        .stall_fetch      (stall_fetch),
        .stall_decode     (stall_decode),
        .stall_execute    (stall_execute),
        .flush_out        (flush_out),
        .redirect_valid   (redirect_valid),
        .redirect_addr    (redirect_addr),
        .busy_vec         (busy_vec)
    );

    // clock
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // Advance to 1 time unit after the next rising edge; inputs change here,
    // outputs are sampled a further #1 later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        dec_valid        = 1'b0;
        dec_rs1_addr     = '0;
        dec_rs2_addr     = '0;
        dec_rs1_used     = 1'b0;
        dec_rs2_used     = 1'b0;
        dec_rd_addr      = '0;
        dec_rd_wen       = 1'b0;
        ex_redirect_req  = 1'b0;
        ex_redirect_addr = '0;
        ex_exception     = 1'b0;
        mem_stall        = 1'b0;
    endtask

    task automatic drive_instr(input logic [4:0] rs1, input logic rs1_used,
                               input logic [4:0] rd, input logic rd_wen);
        dec_valid    = 1'b1;
        dec_rs1_addr = rs1;
        dec_rs1_used = rs1_used;
        dec_rs2_addr = '0;
        dec_rs2_used = 1'b0;
        dec_rd_addr  = rd;
        dec_rd_wen   = rd_wen;
    endtask

    task automatic idle(input int n);
        clear_inputs();
        for (int i = 0; i < n; i++) cyc();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        #1;
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy got=%h exp=%h", busy_vec, 32'h0); end
        checks++; if (flush_out !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", flush_out); end
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_redir_valid got=%b exp=0", redirect_valid); end
        checks++; if (redirect_addr !== 32'h0) begin errors++; $display("FAIL reset_redir_addr got=%h exp=0", redirect_addr); end
        checks++; if ({stall_fetch, stall_decode, stall_execute} !== 3'b000) begin
            errors++; $display("FAIL reset_stalls got=%b exp=000", {stall_fetch, stall_decode, stall_execute}); end
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_raw_hazard();
        idle(3);
        drive_instr(5'd0, 1'b0, 5'd5, 1'b1);        // producer writes r5
        #1;
        checks++; if (stall_decode !== 1'b0) begin errors++; $display("FAIL raw_producer_stall got=%b exp=0", stall_decode); end
        cyc();
        drive_instr(5'd5, 1'b1, 5'd0, 1'b0);        // consumer reads r5
        #1;
        checks++; if (busy_vec !== 32'h0000_0020) begin errors++; $display("FAIL raw_busy_ex got=%h exp=%h", busy_vec, 32'h20); end
        for (int i = 0; i < 3; i++) begin
            #0;
            checks++; if (stall_decode !== 1'b1) begin errors++; $display("FAIL raw_stall_decode c%0d got=%b exp=1", i, stall_decode); end
            checks++; if (stall_fetch !== 1'b1) begin errors++; $display("FAIL raw_stall_fetch c%0d got=%b exp=1", i, stall_fetch); end
            checks++; if (stall_execute !== 1'b0) begin errors++; $display("FAIL raw_stall_execute c%0d got=%b exp=0", i, stall_execute); end
            cyc();
            #1;
        end
        checks++; if (stall_decode !== 1'b0) begin errors++; $display("FAIL raw_issue_cycle4 got=%b exp=0", stall_decode); end
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL raw_busy_cleared got=%h exp=0", busy_vec); end
        cyc();
        clear_inputs();
    endtask

    task automatic test_r0();
        idle(3);
        drive_instr(5'd0, 1'b0, 5'd0, 1'b1);        // writes r0
        #1;
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL r0_busy_issue got=%h exp=0", busy_vec); end
        cyc();
        drive_instr(5'd0, 1'b1, 5'd0, 1'b0);        // reads r0
        #1;
        checks++; if (stall_decode !== 1'b0) begin errors++; $display("FAIL r0_no_stall got=%b exp=0", stall_decode); end
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL r0_busy_after got=%h exp=0", busy_vec); end
        cyc();
        clear_inputs();
    endtask

    task automatic test_redirect();
        idle(4);
        drive_instr(5'd0, 1'b0, 5'd3, 1'b1);        // A: branch writing r3
        cyc();
        drive_instr(5'd0, 1'b0, 5'd7, 1'b1);        // B: younger, writes r7
        ex_redirect_req  = 1'b1;                    // A in EX is taken
        ex_redirect_addr = 32'h40;
        #1;
        checks++; if (flush_out !== 1'b0) begin errors++; $display("FAIL redir_latency got=%b exp=0", flush_out); end
        cyc();
        clear_inputs();
        drive_instr(5'd0, 1'b0, 5'd12, 1'b1);       // must not issue during flush
        #1;
        checks++; if (flush_out !== 1'b1) begin errors++; $display("FAIL redir_flush got=%b exp=1", flush_out); end
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL redir_valid got=%b exp=1", redirect_valid); end
        checks++; if (redirect_addr !== 32'h40) begin errors++; $display("FAIL redir_addr got=%h exp=%h", redirect_addr, 32'h40); end
        checks++; if (stall_decode !== 1'b0) begin errors++; $display("FAIL redir_stall_released got=%b exp=0", stall_decode); end
        checks++; if (busy_vec !== 32'h0000_0088) begin errors++; $display("FAIL redir_busy_pre got=%h exp=%h", busy_vec, 32'h88); end
        cyc();
        clear_inputs();
        #1;
        checks++; if (flush_out !== 1'b0) begin errors++; $display("FAIL redir_one_cycle got=%b exp=0", flush_out); end
        checks++; if (busy_vec !== 32'h0000_0008) begin errors++; $display("FAIL redir_busy_post got=%h exp=%h", busy_vec, 32'h8); end
        cyc();
    endtask

    task automatic test_exception_priority();
        idle(4);
        ex_exception     = 1'b1;
        ex_redirect_req  = 1'b1;
        ex_redirect_addr = 32'h80;
        cyc();
        clear_inputs();
        #1;
        checks++; if (flush_out !== 1'b1) begin errors++; $display("FAIL exc_flush got=%b exp=1", flush_out); end
        checks++; if (redirect_addr !== 32'h100) begin errors++; $display("FAIL exc_addr got=%h exp=%h", redirect_addr, 32'h100); end
        cyc();
    endtask

    task automatic test_stall_then_reset();
        idle(4);
        drive_instr(5'd0, 1'b0, 5'd9, 1'b1);        // producer r9 -> EX
        cyc();
        clear_inputs();
        ex_redirect_req  = 1'b1;
        ex_redirect_addr = 32'h200;
        mem_stall        = 1'b1;
        #1;
        checks++; if ({stall_fetch, stall_decode, stall_execute} !== 3'b111) begin
            errors++; $display("FAIL memstall_stalls got=%b exp=111", {stall_fetch, stall_decode, stall_execute}); end
        cyc();
        #1;
        checks++; if (flush_out !== 1'b0) begin errors++; $display("FAIL memstall_no_flush1 got=%b exp=0", flush_out); end
        checks++; if (busy_vec !== 32'h0000_0200) begin errors++; $display("FAIL memstall_hold got=%h exp=%h", busy_vec, 32'h200); end
        cyc();
        mem_stall = 1'b0;                           // request re-asserted, stall gone
        #1;
        checks++; if (flush_out !== 1'b0) begin errors++; $display("FAIL memstall_no_flush2 got=%b exp=0", flush_out); end
        cyc();
        clear_inputs();
        #1;
        checks++; if (flush_out !== 1'b1) begin errors++; $display("FAIL deferred_flush got=%b exp=1", flush_out); end
        checks++; if (redirect_addr !== 32'h200) begin errors++; $display("FAIL deferred_addr got=%h exp=%h", redirect_addr, 32'h200); end
        checks++; if (busy_vec !== 32'h0000_0200) begin errors++; $display("FAIL deferred_busy got=%h exp=%h", busy_vec, 32'h200); end
        reset = 1'b1;                               // reset during flush
        cyc();
        #1;
        checks++; if (flush_out !== 1'b0) begin errors++; $display("FAIL rst_flush got=%b exp=0", flush_out); end
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL rst_redir_valid got=%b exp=0", redirect_valid); end
        checks++; if (redirect_addr !== 32'h0) begin errors++; $display("FAIL rst_redir_addr got=%h exp=0", redirect_addr); end
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL rst_busy got=%h exp=0", busy_vec); end
        checks++; if ({stall_fetch, stall_decode, stall_execute} !== 3'b000) begin
            errors++; $display("FAIL rst_stalls got=%b exp=000", {stall_fetch, stall_decode, stall_execute}); end
        reset = 1'b0;
        cyc();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_raw_hazard();
        test_r0();
        test_redirect();
        test_exception_priority();
        test_stall_then_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net: the directed sequence is a few hundred ns long.
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
